sccb_cfg_ctrl: RTL and testbench

Camera register-configuration sequencer for the PCAM CSI front end. After a `start` pulse it walks an external register table, issuing one SCCB 3-phase write per entry (device address, 16-bit register address, 8-bit data) on open-drain SCL/SDA. It also executes in-table millisecond delays and stops at an end marker. It generates its own SCL timing from the system clock, so it replaces the free-running 100 kHz divider as the bus clock source.

---
 rtl/sccb_cfg_if.sv | 23 ++
 rtl/sccb_cfg_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_sccb_cfg_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_cfg_if.sv
// Register-table and SCCB pad bundle between the configuration sequencer and
// its environment (table ROM, open-drain pad drivers, host control).
interface sccb_cfg_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        nack_err;
  logic [7:0]  tbl_idx;
  logic [23:0] tbl_data;
  logic        scl_oe;
  logic        sda_oe;
  logic        sda_i;

  modport master (
    input  start, tbl_data, sda_i,
    output busy, done, nack_err, tbl_idx, scl_oe, sda_oe
  );

  modport slave (
    output start, tbl_data, sda_i,
    input  busy, done, nack_err, tbl_idx, scl_oe, sda_oe
  );
endinterface

// File: rtl/sccb_cfg_ctrl.sv
// Camera register-configuration sequencer: walks a register table and issues
// one SCCB 3-phase write per entry, with in-table ms delays and an end marker.
module sccb_cfg_ctrl #(
  parameter int         CLK_DIV  = 250,
  parameter logic [7:0] DEV_ADDR = 8'h78,
  parameter int         MS_TICKS = 100000
) (
  input  logic       clk,
  input  logic       rst,
  sccb_cfg_if.master bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_START  = 4'd3;
  localparam logic [3:0] S_BYTE   = 4'd4;
  localparam logic [3:0] S_STOP   = 4'd5;
  localparam logic [3:0] S_GAP    = 4'd6;
  localparam logic [3:0] S_DELAY  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam int               TICK_W = $clog2(MS_TICKS + 1);
  localparam logic [9:0]       QLAST  = 10'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TLAST = TICK_W'(MS_TICKS - 1);

  logic [3:0]        state;
  logic [9:0]        qcnt;
  logic [1:0]        phase;
  logic [3:0]        bit_idx;
  logic [1:0]        byte_idx;
  logic              fetch_cnt;
  logic [7:0]        ms_left;
  logic [TICK_W-1:0] tick_cnt;
  logic [31:0]       frame;
  logic              sda_p0, sda_p1;

  logic        q_end, bit_end, tick_last, on_bus;
  logic        entry_done, end_hit, finish;
  logic [15:0] reg_addr;
  logic [7:0]  reg_data;

  assign reg_addr  = bus.tbl_data[23:8];
  assign reg_data  = bus.tbl_data[7:0];
  assign q_end     = (qcnt == QLAST);
  assign bit_end   = q_end && (phase == 2'd3);
  assign tick_last = (tick_cnt == TLAST);
  assign on_bus    = (state == S_START) || (state == S_BYTE) ||
                     (state == S_STOP)  || (state == S_GAP);

  always_comb begin
    entry_done = 1'b0;
    end_hit    = 1'b0;
    case (state)
      S_DECODE: begin
        end_hit    = (bus.tbl_data == 24'hFFFFFF);
        entry_done = !end_hit && (reg_addr == 16'hFFFE) && (reg_data == 8'd0);
      end
      S_GAP:   entry_done = bit_end;
      S_DELAY: entry_done = tick_last && (ms_left == 8'd1);
      default: ;
    endcase
  end

  assign finish = end_hit || (entry_done && (bus.tbl_idx == 8'hFF));

  // Outgoing frame: ID byte then the table entry, shifted out MSB-first
  always_ff @(posedge clk) begin
    if (state == S_DECODE)
      frame <= {DEV_ADDR, bus.tbl_data};
    else if (state == S_BYTE && bit_end && bit_idx < 4'd8)
      frame <= {frame[30:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.nack_err <= 1'b0;
      bus.tbl_idx  <= 8'd0;
      bus.scl_oe   <= 1'b0;
      bus.sda_oe   <= 1'b0;
      qcnt         <= 10'd0;
      phase        <= 2'd0;
      bit_idx      <= 4'd0;
      byte_idx     <= 2'd0;
      fetch_cnt    <= 1'b0;
      ms_left      <= 8'd0;
      tick_cnt     <= '0;
      sda_p0       <= 1'b1;
      sda_p1       <= 1'b1;
    end else begin
      sda_p0   <= bus.sda_i;
      sda_p1   <= sda_p0;
      bus.done <= 1'b0;

      if (on_bus) begin
        if (q_end) begin
          qcnt  <= 10'd0;
          phase <= phase + 2'd1;
        end else begin
          qcnt <= qcnt + 10'd1;
        end
      end

      case (state)
        S_IDLE: if (bus.start) begin
          state        <= S_FETCH;
          bus.tbl_idx  <= 8'd0;
          bus.busy     <= 1'b1;
          bus.nack_err <= 1'b0;
          fetch_cnt    <= 1'b0;
        end
        S_FETCH: begin
          fetch_cnt <= 1'b1;
          if (fetch_cnt) state <= S_DECODE;
        end
        S_DECODE: begin
          qcnt  <= 10'd0;
          phase <= 2'd0;
          if (!end_hit) begin
            if (reg_addr == 16'hFFFE) begin
              if (reg_data != 8'd0) begin
                state    <= S_DELAY;
                ms_left  <= reg_data;
                tick_cnt <= '0;
              end
            end else begin
              state <= S_START;
            end
          end
        end
        // Bus idle-high, SDA falls at Q2 with SCL released
        S_START: begin
          if (q_end && phase == 2'd1) bus.sda_oe <= 1'b1;
          if (bit_end) begin
            state       <= S_BYTE;
            bit_idx     <= 4'd0;
            byte_idx    <= 2'd0;
            bus.scl_oe  <= 1'b1;
            bus.sda_oe  <= ~frame[31];
          end
        end
        S_BYTE: begin
          if (q_end && phase == 2'd1) bus.scl_oe <= 1'b0;
          if (q_end && phase == 2'd2 && bit_idx == 4'd8 && sda_p1)
            bus.nack_err <= 1'b1;
          if (bit_end) begin
            bus.scl_oe <= 1'b1;
            if (bit_idx < 4'd7) begin
              bit_idx    <= bit_idx + 4'd1;
              bus.sda_oe <= ~frame[30];
            end else if (bit_idx == 4'd7) begin
              bit_idx    <= 4'd8;
              bus.sda_oe <= 1'b0;
            end else if (byte_idx == 2'd3) begin
              state      <= S_STOP;
              bus.sda_oe <= 1'b1;
            end else begin
              byte_idx   <= byte_idx + 2'd1;
              bit_idx    <= 4'd0;
              bus.sda_oe <= ~frame[31];
            end
          end
        end
        S_STOP: begin
          if (q_end && phase == 2'd1) bus.scl_oe <= 1'b0;
          if (q_end && phase == 2'd2) bus.sda_oe <= 1'b0;
          if (bit_end) state <= S_GAP;
        end
        S_GAP: ;
        S_DELAY: begin
          if (tick_last) begin
            tick_cnt <= '0;
            ms_left  <= ms_left - 8'd1;
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Entry retirement overrides the per-state next-state choice above
      if (finish) begin
        state    <= S_DONE;
        bus.done <= 1'b1;
        bus.busy <= 1'b0;
      end else if (entry_done) begin
        state       <= S_FETCH;
        fetch_cnt   <= 1'b0;
        bus.tbl_idx <= bus.tbl_idx + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sccb_cfg_ctrl.sv
// Scoreboarded bench: a table-walk reference model predicts the SCCB event
// stream and done timing; a bus decoder / slave model checks what appears.
module tb_sccb_cfg_ctrl;
  localparam int CDIV     = 4;
  localparam int MST      = 10;
  localparam int BIT_CLKS = 4 * CDIV;

  typedef struct {
    int          kind;   // 0 START, 1 BYTE, 2 STOP, 3 DONE
    logic [7:0]  val;
    int unsigned cyc;
    logic        nack;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] rom [256];
  logic        slave_pull = 1'b0;
  bit          ack_en = 1'b1;
  bit          mon_en = 1'b0;
  bit          allow_zero = 1'b0;
  bit          done_seen = 1'b0;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  ev_t         expq[$];

  sccb_cfg_if bus();

  sccb_cfg_ctrl #(.CLK_DIV(CDIV), .DEV_ADDR(8'h78), .MS_TICKS(MST)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.tbl_data <= rom[bus.tbl_idx];
  assign bus.sda_i = ~(bus.sda_oe | slave_pull);

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_ev(input int kind, input logic [7:0] val, input int unsigned c, input logic nack);
    ev_t e;
    e.kind = kind; e.val = val; e.cyc = c; e.nack = nack;
    expq.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] val, input logic nack);
    ev_t e;
    bit  ok;
    n_chk++;
    if (expq.size() == 0) begin
      $display("FAIL unexpected_event kind=%0d val=%h cyc=%0d", kind, val, cyc);
      return;
    end
    e  = expq.pop_front();
    ok = (e.kind == kind);
    if (kind == 1) ok = ok && (e.val == val);
    if (kind == 2) ok = ok && (e.nack == nack);
    if (kind == 3) ok = ok && (e.val == val) && (e.nack == nack) && (e.cyc == cyc);
    if (ok) n_pass++;
    else $display("FAIL bus_event got kind=%0d val=%h nack=%0b cyc=%0d want kind=%0d val=%h nack=%0b cyc=%0d",
                  kind, val, nack, cyc, e.kind, e.val, e.nack, e.cyc);
  endtask

  // Bus decoder, ACKing slave, done monitor and table-index progression
  initial begin
    logic       scl, sda, pscl, psda;
    logic [7:0] cur, pidx;
    int         bitpos;
    pscl = 1'b1; psda = 1'b1; cur = 8'd0; pidx = 8'd0; bitpos = 0;
    forever begin
      @(negedge clk);
      scl = ~bus.scl_oe;
      sda = bus.sda_i;
      if (mon_en) begin
        if (scl && pscl && psda && !sda) begin
          expect_ev(0, 8'd0, 1'b0);
          bitpos = 0;
        end else if (scl && pscl && !psda && sda) begin
          expect_ev(2, 8'd0, bus.nack_err);
          bitpos = 0;
        end else if (scl && !pscl) begin
          if (bitpos < 8) begin
            cur = {cur[6:0], sda};
            bitpos++;
          end else begin
            expect_ev(1, cur, 1'b0);
            bitpos = 0;
          end
        end else if (!scl && pscl) begin
          slave_pull = ack_en && (bitpos == 8);
        end
        if (bus.done) begin
          expect_ev(3, bus.tbl_idx, bus.nack_err);
          chk(bus.busy == 1'b0, "busy_at_done", bus.busy, 0);
          done_seen  = 1'b1;
          allow_zero = 1'b0;
        end
        if (bus.tbl_idx != pidx) begin
          if (allow_zero && bus.tbl_idx == 8'd0) allow_zero = 1'b0;
          else chk(bus.tbl_idx == pidx + 8'd1, "idx_step", bus.tbl_idx, pidx + 8'd1);
        end
      end else begin
        slave_pull = 1'b0;
        bitpos     = 0;
      end
      pidx = bus.tbl_idx;
      pscl = scl;
      psda = sda;
    end
  end

  // Reference model: walk the table by its rules, predict events and done time
  task automatic run_table(input bit ack, input int mid_start);
    int unsigned t, acc;
    logic [7:0]  last;
    logic [23:0] e;
    bit          any_wr;
    int          guard;
    ack_en = ack;
    t = 0; last = 8'd0; any_wr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      e    = rom[i];
      last = 8'(i);
      if (e == 24'hFFFFFF) begin
        t += 3;
        break;
      end else if (e[23:8] == 16'hFFFE) begin
        t += 3 + int'(e[7:0]) * MST;
      end else begin
        t += 3 + 39 * BIT_CLKS;
        any_wr = 1'b1;
        push_ev(0, 8'd0, 0, 1'b0);
        push_ev(1, 8'h78, 0, 1'b0);
        push_ev(1, e[23:16], 0, 1'b0);
        push_ev(1, e[15:8], 0, 1'b0);
        push_ev(1, e[7:0], 0, 1'b0);
        push_ev(2, 8'd0, 0, !ack);
      end
    end
    allow_zero = 1'b1;
    done_seen  = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    bus.start = 1'b0;
    push_ev(3, last, acc + t, !ack && any_wr);
    @(negedge clk);
    chk(bus.busy == 1'b1, "busy_after_start", bus.busy, 1);
    chk(bus.nack_err == 1'b0, "nack_cleared_by_start", bus.nack_err, 0);
    if (mid_start > 0) begin
      repeat (mid_start) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    guard = 0;
    while (!done_seen && guard < int'(t) + 200) begin
      @(negedge clk);
      guard++;
    end
    chk(done_seen, "done_seen", done_seen, 1);
    repeat (20) @(negedge clk);
    chk(expq.size() == 0, "scoreboard_drained", expq.size(), 0);
    expq.delete();
  endtask

  function automatic logic [23:0] rand_write();
    logic [23:0] w;
    w = 24'($urandom);
    w[23] = 1'b0;
    return w;
  endfunction

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 24'hFFFFFF;
    repeat (4) @(negedge clk);
    chk(bus.busy == 1'b0, "rst_busy", bus.busy, 0);
    chk(bus.done == 1'b0, "rst_done", bus.done, 0);
    chk(bus.nack_err == 1'b0, "rst_nack", bus.nack_err, 0);
    chk(bus.tbl_idx == 8'd0, "rst_idx", bus.tbl_idx, 0);
    chk(bus.scl_oe == 1'b0, "rst_scl", bus.scl_oe, 0);
    chk(bus.sda_oe == 1'b0, "rst_sda", bus.sda_oe, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    rom[0] = 24'h300882; rom[1] = 24'hFFFFFF;
    run_table(1'b1, 0);
    run_table(1'b0, 0);

    rom[0] = 24'hFFFE03; rom[1] = 24'hFFFFFF;
    run_table(1'b1, 0);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++)
        rom[i] = (i % 2 == 0) ? rand_write() : {16'hFFFE, 8'($urandom_range(0, 3))};
      rom[5] = 24'hFFFFFF;
      run_table(1'($urandom_range(0, 1)), (r == 0) ? 300 : 0);
    end

    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 4) == 0) ? rand_write()
                                           : {16'hFFFE, 8'($urandom_range(0, 1))};
    run_table(1'b1, 0);

    rom[0] = 24'h3103A5; rom[1] = 24'hFFFFFF;
    push_ev(0, 8'd0, 0, 1'b0);
    push_ev(1, 8'h78, 0, 1'b0);
    ack_en = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3 + BIT_CLKS + 9 * BIT_CLKS + 2 * BIT_CLKS + 2) @(posedge clk);
    #2;
    chk(bus.scl_oe == 1'b1, "pre_rst_scl_low", bus.scl_oe, 1);
    chk(expq.size() == 0, "first_byte_seen", expq.size(), 0);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk(bus.scl_oe == 1'b0, "rst_mid_scl", bus.scl_oe, 0);
    chk(bus.sda_oe == 1'b0, "rst_mid_sda", bus.sda_oe, 0);
    chk(bus.busy == 1'b0, "rst_mid_busy", bus.busy, 0);
    chk(bus.tbl_idx == 8'd0, "rst_mid_idx", bus.tbl_idx, 0);
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    run_table(1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
